// File: rtl/svf_sched_pkg.sv
// Shared types and Q8.4 arithmetic helpers for the time-multiplexed state-variable filter scheduler.
package svf_sched_pkg;

  localparam int W_AUD = 8;   // signed audio sample width
  localparam int W_Q   = 12;  // signed Q8.4 state/datapath width
  localparam int W_A1  = 11;  // cutoff coefficient width

  typedef enum logic [1:0] {
    MODE_LP  = 2'b00,
    MODE_BP  = 2'b01,
    MODE_HP  = 2'b10,
    MODE_BYP = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic signed [W_Q-1:0] sat12(input logic signed [W_Q:0] x);
    if (x > 13'sd2047)       return 12'sh7FF;
    else if (x < -13'sd2048) return 12'sh800;
    else                     return x[W_Q-1:0];
  endfunction

  function automatic logic signed [W_Q-1:0] sat_add(input logic signed [W_Q-1:0] a,
                                                    input logic signed [W_Q-1:0] b);
    logic signed [W_Q:0] s;
    s = {a[W_Q-1], a} + {b[W_Q-1], b};
    return sat12(s);
  endfunction

  function automatic logic signed [W_Q-1:0] sat_sub(input logic signed [W_Q-1:0] a,
                                                    input logic signed [W_Q-1:0] b);
    logic signed [W_Q:0] s;
    s = {a[W_Q-1], a} - {b[W_Q-1], b};
    return sat12(s);
  endfunction

endpackage

// File: rtl/svf_voice_scheduler_if.sv
// Control/data bundle between the voice generators, the scheduler and the output mixer.
interface svf_voice_scheduler_if #(
  parameter int NUM_CH = 3
);
  localparam int MIX_W = 8 + $clog2(NUM_CH);

  logic                      sample_tick;
  logic [8*NUM_CH-1:0]       audio_in;
  logic [11*NUM_CH-1:0]      alpha1;
  logic [2*NUM_CH-1:0]       alpha2;
  logic [2*NUM_CH-1:0]       mode;
  logic                      state_clr;
  logic                      ovr_clr;
  logic                      busy;
  logic                      out_valid;
  logic [2:0]                out_ch;
  logic signed [7:0]         out_sample;
  logic                      frame_done;
  logic signed [MIX_W-1:0]   mix_out;
  logic                      overrun;

  modport master (
    output sample_tick, audio_in, alpha1, alpha2, mode, state_clr, ovr_clr,
    input  busy, out_valid, out_ch, out_sample, frame_done, mix_out, overrun
  );

  modport slave (
    input  sample_tick, audio_in, alpha1, alpha2, mode, state_clr, ovr_clr,
    output busy, out_valid, out_ch, out_sample, frame_done, mix_out, overrun
  );

endinterface

// File: rtl/svf_step.sv
// One combinational Chamberlin SVF step in saturating Q8.4: produces hp, next bp and next lp.
module svf_step
  import svf_sched_pkg::*;
(
  input  logic signed [W_AUD-1:0] i_audio,
  input  logic signed [W_Q-1:0]   i_bp,
  input  logic signed [W_Q-1:0]   i_lp,
  input  logic [6:0]              i_f,       // alpha1[10:4]
  input  logic [1:0]              i_alpha2,
  output logic signed [W_Q-1:0]   o_hp,
  output logic signed [W_Q-1:0]   o_bp,
  output logic signed [W_Q-1:0]   o_lp
);

  // Shift-and-add multiply: f[10-k] weights x>>>k, so the MSB of f is the 1/16 term.
  function automatic logic signed [W_Q-1:0] f_mul(input logic signed [W_Q-1:0] x,
                                                  input logic [6:0] f);
    logic signed [W_Q-1:0] acc;
    acc = '0;
    for (int k = 4; k <= 10; k++) begin
      if (f[10-k]) acc = acc + (x >>> k);
    end
    return acc;
  endfunction

  function automatic logic signed [W_Q-1:0] q_mul(input logic signed [W_Q-1:0] x,
                                                  input logic [1:0] a2);
    return (a2[1] ? (x >>> 1) : 12'sd0) + (a2[0] ? (x >>> 2) : 12'sd0);
  endfunction

  logic signed [W_Q-1:0] w_in;
  logic signed [W_Q-1:0] w_in_lp;

  assign w_in    = {i_audio, 4'b0000};
  assign w_in_lp = sat_sub(w_in, i_lp);
  assign o_hp    = sat_sub(w_in_lp, q_mul(i_bp, i_alpha2));
  assign o_bp    = sat_add(i_bp, f_mul(o_hp, i_f));
  assign o_lp    = sat_add(i_lp, f_mul(o_bp, i_f));

endmodule

// File: rtl/svf_voice_scheduler.sv
// Shares one svf_step across NUM_CH channels per sample_tick and emits per-channel taps plus a frame mix.
// Optional per-channel cutoff slewing is enabled by defining SVF_CUTOFF_SLEW_EN.
module svf_voice_scheduler
  import svf_sched_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int SLEW_STEP = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  svf_voice_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int MIX_W = W_AUD + $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 8 || SLEW_STEP < 1) begin : g_bad_cfg
    $error("svf_voice_scheduler: NUM_CH must be 2..8 and SLEW_STEP >= 1");
  end

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    w_busy;
  logic                    w_run;
  logic                    w_done;

  logic [2:0]              r_ch;
  logic [IDX_W-1:0]        w_idx;
  logic signed [W_AUD-1:0] r_snap [NUM_CH];
  logic signed [W_Q-1:0]   r_bp   [NUM_CH];
  logic signed [W_Q-1:0]   r_lp   [NUM_CH];
  logic                    r_clr_pend;
  logic signed [MIX_W-1:0] r_acc;

  logic                    r_out_valid;
  logic [2:0]              r_out_ch;
  logic signed [W_AUD-1:0] r_out_sample;
  logic                    r_frame_done;
  logic signed [MIX_W-1:0] r_mix;
  logic                    r_overrun;

  mode_e                   w_mode;
  logic [6:0]              w_f;
  logic signed [W_Q-1:0]   w_hp;
  logic signed [W_Q-1:0]   w_bp_n;
  logic signed [W_Q-1:0]   w_lp_n;
  logic signed [W_AUD-1:0] w_tap;

  assign w_idx  = r_ch[IDX_W-1:0];
  assign w_mode = mode_e'(bus.mode[2*w_idx +: 2]);

  // FSM: state register
  // NOTE: every clocked process uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  // NOTE: each combinational output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.sample_tick) w_state_nxt = S_RUN;
      S_RUN:   if (r_ch == 3'(NUM_CH-1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: decoded state outputs
  always_comb begin
    w_busy = 1'b0;
    w_run  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_RUN:   begin w_busy = 1'b1; w_run  = 1'b1; end
      S_DONE:  begin w_busy = 1'b1; w_done = 1'b1; end
      default: begin w_busy = 1'b0; end
    endcase
  end

`ifdef SVF_CUTOFF_SLEW_EN
  logic [W_A1-1:0] r_cur_a1 [NUM_CH];
  logic [W_A1-1:0] w_a1_cur;
  logic [W_A1-1:0] w_a1_tgt;
  logic [W_A1-1:0] w_a1_nxt;

  assign w_a1_cur = r_cur_a1[w_idx];
  assign w_a1_tgt = bus.alpha1[W_A1*w_idx +: W_A1];
  assign w_f      = w_a1_cur[10:4];

  // Step toward the target, landing on it exactly when within one step.
  always_comb begin
    w_a1_nxt = w_a1_tgt;
    if (int'(w_a1_tgt) > int'(w_a1_cur) + SLEW_STEP)
      w_a1_nxt = w_a1_cur + W_A1'(SLEW_STEP);
    else if (int'(w_a1_tgt) + SLEW_STEP < int'(w_a1_cur))
      w_a1_nxt = w_a1_cur - W_A1'(SLEW_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) r_cur_a1[k] <= '0;
    end else if (w_run) begin
      r_cur_a1[w_idx] <= w_a1_nxt;
    end
  end
`else
  assign w_f = bus.alpha1[W_A1*w_idx + 4 +: 7];
`endif

  svf_step u_step (
    .i_audio  (r_snap[w_idx]),
    .i_bp     (r_bp[w_idx]),
    .i_lp     (r_lp[w_idx]),
    .i_f      (w_f),
    .i_alpha2 (bus.alpha2[2*w_idx +: 2]),
    .o_hp     (w_hp),
    .o_bp     (w_bp_n),
    .o_lp     (w_lp_n)
  );

  always_comb begin
    w_tap = w_lp_n[11:4];
    unique case (w_mode)
      MODE_LP:  w_tap = w_lp_n[11:4];
      MODE_BP:  w_tap = w_bp_n[11:4];
      MODE_HP:  w_tap = w_hp[11:4];
      MODE_BYP: w_tap = r_snap[w_idx];
      default:  w_tap = w_lp_n[11:4];
    endcase
  end

  // NOTE: the per-channel arrays are small architectural register files, so they reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_snap[k] <= '0;
        r_bp[k]   <= '0;
        r_lp[k]   <= '0;
      end
      r_ch         <= '0;
      r_clr_pend   <= 1'b0;
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_out_ch     <= '0;
      r_out_sample <= '0;
      r_frame_done <= 1'b0;
      r_mix        <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;

      if (bus.sample_tick && w_busy) r_overrun <= 1'b1;
      else if (bus.ovr_clr)          r_overrun <= 1'b0;

      if (bus.state_clr && w_busy) r_clr_pend <= 1'b1;

      if (w_run) begin
        if (w_mode != MODE_BYP) begin
          r_bp[w_idx] <= w_bp_n;
          r_lp[w_idx] <= w_lp_n;
        end
        r_out_valid  <= 1'b1;
        r_out_ch     <= r_ch;
        r_out_sample <= w_tap;
        r_acc        <= r_acc + {{(MIX_W-W_AUD){w_tap[W_AUD-1]}}, w_tap};
        r_ch         <= r_ch + 3'd1;
      end else if (w_done) begin
        r_frame_done <= 1'b1;
        r_mix        <= r_acc;
        r_acc        <= '0;
        r_clr_pend   <= 1'b0;
        // A clear requested during the frame lands here, after the last channel has been written.
        if (r_clr_pend || bus.state_clr) begin
          for (int k = 0; k < NUM_CH; k++) begin
            r_bp[k] <= '0;
            r_lp[k] <= '0;
          end
        end
      end else begin
        if (bus.state_clr) begin
          for (int k = 0; k < NUM_CH; k++) begin
            r_bp[k] <= '0;
            r_lp[k] <= '0;
          end
        end
        if (bus.sample_tick) begin
          for (int k = 0; k < NUM_CH; k++) r_snap[k] <= bus.audio_in[W_AUD*k +: W_AUD];
          r_ch <= '0;
        end
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_ch     = r_out_ch;
  assign bus.out_sample = r_out_sample;
  assign bus.frame_done = r_frame_done;
  assign bus.mix_out    = r_mix;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_svf_voice_scheduler.sv
// Scoreboard bench for svf_voice_scheduler: an integer reference model predicts every tap and frame mix.
module tb_svf_voice_scheduler;

  localparam int NUM_CH = 3;
  localparam int SLEW   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  svf_voice_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  svf_voice_scheduler #(.NUM_CH(NUM_CH), .SLEW_STEP(SLEW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int mix_q[$];
  int m_bp[NUM_CH];
  int m_lp[NUM_CH];
  int m_a1[NUM_CH];
  int d_audio[NUM_CH];
  int d_a1[NUM_CH];
  int d_a2[NUM_CH];
  int d_md[NUM_CH];
  bit exp_ovr;
  int last_ch0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic int sat(input int x);
    if (x > 2047)  return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  function automatic int fmul(input int x, input int a1);
    int s = 0;
    for (int k = 4; k <= 10; k++)
      if (((a1 >> (14 - k)) & 1) == 1) s += (x >>> k);
    return s;
  endfunction

  function automatic int qmul(input int x, input int a2);
    int s = 0;
    if ((a2 & 2) != 0) s += (x >>> 1);
    if ((a2 & 1) != 0) s += (x >>> 2);
    return s;
  endfunction

  task automatic zero_state();
    for (int c = 0; c < NUM_CH; c++) begin
      m_bp[c] = 0;
      m_lp[c] = 0;
    end
  endtask

  task automatic model_frame();
    int mix = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      int a1, hp, bp, lp, tap;
      a1 = d_a1[c];
`ifdef SVF_CUTOFF_SLEW_EN
      a1 = m_a1[c];
      if (d_a1[c] > m_a1[c]) m_a1[c] = (m_a1[c] + SLEW < d_a1[c]) ? m_a1[c] + SLEW : d_a1[c];
      else                   m_a1[c] = (m_a1[c] - SLEW > d_a1[c]) ? m_a1[c] - SLEW : d_a1[c];
`endif
      hp = sat(sat(d_audio[c] * 16 - m_lp[c]) - qmul(m_bp[c], d_a2[c]));
      bp = sat(m_bp[c] + fmul(hp, a1));
      lp = sat(m_lp[c] + fmul(bp, a1));
      case (d_md[c])
        0:       tap = lp >>> 4;
        1:       tap = bp >>> 4;
        2:       tap = hp >>> 4;
        default: tap = d_audio[c];
      endcase
      if (d_md[c] != 3) begin
        m_bp[c] = bp;
        m_lp[c] = lp;
      end
      exp_q.push_back(c * 256 + (tap & 255));
      mix += tap;
    end
    mix_q.push_back(mix);
  endtask

  // ---------------- stimulus ----------------
  task automatic drive_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      bus.audio_in[8*c +: 8] = 8'(d_audio[c]);
      bus.alpha1[11*c +: 11] = 11'(d_a1[c]);
      bus.alpha2[2*c +: 2]   = 2'(d_a2[c]);
      bus.mode[2*c +: 2]     = 2'(d_md[c]);
    end
  endtask

  task automatic random_drive();
    for (int c = 0; c < NUM_CH; c++) begin
      d_audio[c] = int'($urandom_range(0, 255)) - 128;
      d_a1[c]    = int'($urandom_range(0, 2047));
      d_a2[c]    = int'($urandom_range(0, 3));
      d_md[c]    = int'($urandom_range(0, 3));
    end
  endtask

  // One frame; optionally pokes tick/ovr_clr/state_clr for one cycle while busy (busy_at = cycles after tick).
  task automatic run_frame(input int busy_at, input bit b_tick, input bit b_ovr,
                           input bit b_sclr, input bit idle_sclr);
    int cnt;
    bit got;
    @(posedge clk); #1;
    drive_inputs();
    if (idle_sclr) zero_state();
    model_frame();
    bus.sample_tick = 1'b1;
    bus.state_clr   = idle_sclr;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    bus.state_clr   = 1'b0;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) check("busy_after_tick", int'(bus.busy), 1);
      if (bus.frame_done) got = 1'b1;
      if (cnt == busy_at) begin
        bus.sample_tick = b_tick;
        bus.ovr_clr     = b_ovr;
        bus.state_clr   = b_sclr;
        if (b_tick)     exp_ovr = 1'b1;
        else if (b_ovr) exp_ovr = 1'b0;
        if (b_sclr)     zero_state();
      end else if (cnt == busy_at + 1) begin
        bus.sample_tick = 1'b0;
        bus.ovr_clr     = 1'b0;
        bus.state_clr   = 1'b0;
      end
    end
    check("tick_to_frame_done", cnt, NUM_CH + 2);
    check("overrun_flag", int'(bus.overrun), int'(exp_ovr));
  endtask

  task automatic clear_ovr();
    @(posedge clk); #1;
    bus.ovr_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clk);
    check("overrun_after_clr", int'(bus.overrun), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) check("out_valid_unexpected", int'(bus.out_valid), 0);
          else check("ch_sample", int'({bus.out_ch, bus.out_sample}), exp_q.pop_front());
          if (bus.out_ch == 3'd0) last_ch0 = int'(bus.out_sample);
        end
        if (bus.frame_done) begin
          if (mix_q.size() == 0) check("frame_done_unexpected", int'(bus.frame_done), 0);
          else check("mix_out", int'(bus.mix_out), mix_q.pop_front());
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int fd_seen;
    bus.sample_tick = 1'b0;
    bus.audio_in    = '0;
    bus.alpha1      = '0;
    bus.alpha2      = '0;
    bus.mode        = '0;
    bus.state_clr   = 1'b0;
    bus.ovr_clr     = 1'b0;
    zero_state();
    for (int c = 0; c < NUM_CH; c++) m_a1[c] = 0;
    exp_ovr  = 1'b0;
    last_ch0 = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",       int'(bus.busy), 0);
    check("rst_out_valid",  int'(bus.out_valid), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_out_sample", int'(bus.out_sample), 0);
    check("rst_out_ch",     int'(bus.out_ch), 0);
    check("rst_mix_out",    int'(bus.mix_out), 0);
    check("rst_overrun",    int'(bus.overrun), 0);
    rst_n = 1'b1;

    // Reset asserted mid-frame aborts it
    random_drive();
    @(posedge clk); #1;
    drive_inputs();
    bus.sample_tick = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    @(negedge clk);
    check("abort_busy_before", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy_in_reset", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    zero_state();
    for (int c = 0; c < NUM_CH; c++) m_a1[c] = 0;
    fd_seen = 0;
    repeat (NUM_CH + 4) begin
      @(negedge clk);
      if (bus.frame_done) fd_seen++;
    end
    check("abort_no_frame_done", fd_seen, 0);

    // All bypass, known samples
    d_audio = '{8'h10, 8'h20, 8'h30};
    for (int c = 0; c < NUM_CH; c++) begin
      d_a1[c] = 0;
      d_a2[c] = 0;
      d_md[c] = 3;
    end
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bypass_mix", int'(bus.mix_out), 96);

    // Tick while busy, then clear; clear coincident with busy tick keeps overrun
    run_frame(2, 1'b1, 1'b0, 1'b0, 1'b0);
    clear_ovr();
    run_frame(NUM_CH + 1, 1'b1, 1'b1, 1'b0, 1'b0);
    clear_ovr();

    // ch0 low-pass step response
    for (int c = 0; c < NUM_CH; c++) begin
      d_audio[c] = 0;
      d_a1[c]    = 0;
      d_a2[c]    = 0;
      d_md[c]    = 3;
    end
    d_audio[0] = 'h40;
    d_a1[0]    = 'h7F0;
    d_a2[0]    = 3;
    d_md[0]    = 0;
    for (int f = 1; f <= 500; f++) begin
      run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SVF_CUTOFF_SLEW_EN
      if (f == 127) check("slew_reaches_target", int'(u_dut.r_cur_a1[0]), 'h7F0);
`else
      if (f == 1) begin
        check("lp_frame1_bp", int'(u_dut.r_bp[0]), 'h07F);
        check("lp_frame1_lp", int'(u_dut.r_lp[0]), 'h00B);
        check("lp_frame1_out", last_ch0, 0);
      end
`endif
    end
    check("lp_converged", int'(last_ch0 >= 'h3F && last_ch0 <= 'h40), 1);

    // state_clr during RUN completes the frame, then zero state
    run_frame(2, 1'b0, 1'b0, 1'b1, 1'b0);
    d_audio[0] = 0;
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_bp_zero", int'(u_dut.r_bp[0]), 0);
    check("clr_lp_zero", int'(u_dut.r_lp[0]), 0);
    check("clr_out_zero", last_ch0, 0);

    // Randomized frames
    for (int i = 0; i < 200; i++) begin
      bit bt;
      random_drive();
      bt = ($urandom_range(0, 3) == 0);
      run_frame(bt ? int'($urandom_range(1, NUM_CH + 1)) : 0, bt, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 9) == 0) clear_ovr();
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("mix_q_drained", mix_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
